// File: rtl/ov_pkg.sv
// ov_pkg: shared definitions for the camera init sequencer.
//   - ov_state_e : sequencer FSM states
//   - END_MARK / DELAY_MARK : special register codes in the init table
//   - STAT_BUSY / STAT_NACK : bit positions in stu_iic_status
package ov_pkg;

  typedef enum logic [3:0] {
    StPwrup,
    StFetch,
    StIssue,
    StWaitHi,
    StWaitLo,
    StCheck,
    StDelay,
    StHostIdle,
    StHostIssue
  } ov_state_e;

  localparam logic [7:0] END_MARK   = 8'hFF;
  localparam logic [7:0] DELAY_MARK = 8'hFE;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_NACK = 1;

endpackage

// File: rtl/ov_init_rom.sv
// ov_init_rom: camera init table, 256 x 16, synchronous read (1-cycle latency).
//   clk_sys : system clock
//   addr    : table index
//   data    : {register, value} of entry addr, valid the cycle after addr is presented
// Unlisted entries read as the end marker so a short table always terminates.
module ov_init_rom
  import ov_pkg::*;
(
  input  logic        clk_sys,
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  logic [15:0] rom_val;

  always_comb begin
    case (addr)
      8'd0:    rom_val = {8'h12, 8'h80};      // soft reset
      8'd1:    rom_val = {DELAY_MARK, 8'h01}; // 1 ms settle
      8'd2:    rom_val = {8'h11, 8'h01};      // clock prescaler
      default: rom_val = {END_MARK, 8'h00};
    endcase
  end

  always_ff @(posedge clk_sys) begin
    data <= rom_val;
  end

endmodule

// File: rtl/ov_init_seq.sv
// ov_init_seq: power-up delay, init-table walker and host arbiter in front of the SCCB master.
//   clk_sys, rst_n                      : clock, asynchronous active-low reset
//   pluse_us                            : 1 us strobe
//   host_devid/addr/wdata, host_write/read : host command from the register block
//   host_busy, host_rdata, host_ovf     : host command status
//   cfg_iic_*, act_iic_write/read       : command and one-cycle request to the SCCB master
//   stu_iic_status, stu_iic_rdata       : SCCB master status (bit0 busy, bit1 NACK) and read data
//   init_done, init_err                 : table complete / sticky failure
module ov_init_seq
  import ov_pkg::*;
#(
  parameter logic [7:0]  DEVID     = 8'h42,
  parameter int unsigned PWRUP_US  = 1000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned BUSY_TO   = 15
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pluse_us,
  input  logic [7:0] host_devid,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       host_write,
  input  logic       host_read,
  output logic       host_busy,
  output logic [7:0] host_rdata,
  output logic       host_ovf,
  output logic [7:0] cfg_iic_devid,
  output logic [7:0] cfg_iic_addr,
  output logic [7:0] cfg_iic_wdata,
  output logic       act_iic_write,
  output logic       act_iic_read,
  input  logic [1:0] stu_iic_status,
  input  logic [7:0] stu_iic_rdata,
  output logic       init_done,
  output logic       init_err
);

  localparam logic [9:0] UsLast    = 10'd999;
  localparam logic [9:0] PwrupLast = 10'(PWRUP_US - 1);
  localparam logic [7:0] RetryMax  = 8'(MAX_RETRY);
  localparam logic [7:0] BusyLast  = 8'(BUSY_TO - 1);

  ov_state_e   state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic        fetch_ph_q, fetch_ph_d;
  logic [9:0]  us_cnt_q, us_cnt_d;
  logic [7:0]  ms_cnt_q, ms_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic        nack_q, nack_d;
  logic        pend_q, pend_d, pend_rd_q, pend_rd_d;
  logic [7:0]  pend_devid_q, pend_devid_d, pend_addr_q, pend_addr_d, pend_wdata_q, pend_wdata_d;
  logic [7:0]  cfg_devid_q, cfg_devid_d, cfg_addr_q, cfg_addr_d, cfg_wdata_q, cfg_wdata_d;
  logic        act_wr_q, act_wr_d, act_rd_q, act_rd_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ovf_q, ovf_d, done_q, done_d, err_q, err_d;
  logic [15:0] rom_data;
  logic        advance, host_done, busy;

  assign busy = stu_iic_status[STAT_BUSY];

  ov_init_rom u_rom (
    .clk_sys (clk_sys),
    .addr    (index_q),
    .data    (rom_data)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    fetch_ph_d   = 1'b0;
    us_cnt_d     = us_cnt_q;
    ms_cnt_d     = ms_cnt_q;
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
    nack_d       = nack_q;
    pend_d       = pend_q;
    pend_rd_d    = pend_rd_q;
    pend_devid_d = pend_devid_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    cfg_devid_d  = cfg_devid_q;
    cfg_addr_d   = cfg_addr_q;
    cfg_wdata_d  = cfg_wdata_q;
    act_wr_d     = 1'b0;
    act_rd_d     = 1'b0;
    rdata_d      = rdata_q;
    ovf_d        = ovf_q;
    done_d       = done_q;
    err_d        = err_q;
    advance      = 1'b0;
    host_done    = 1'b0;

    unique case (state_q)
      StPwrup: begin
        if (pluse_us) begin
          if (us_cnt_q == PwrupLast) begin
            us_cnt_d = '0;
            index_d  = '0;
            state_d  = StFetch;
          end else begin
            us_cnt_d = us_cnt_q + 10'd1;
          end
        end
      end
      StFetch: begin
        // First cycle only presents the index; ROM data is valid in the second.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else if (rom_data[15:8] == END_MARK) begin
          done_d  = 1'b1;
          state_d = StHostIdle;
        end else if (rom_data[15:8] == DELAY_MARK) begin
          if (rom_data[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            us_cnt_d = '0;
            ms_cnt_d = '0;
            state_d  = StDelay;
          end
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        cfg_devid_d = DEVID;
        cfg_addr_d  = rom_data[15:8];
        cfg_wdata_d = rom_data[7:0];
        act_wr_d    = 1'b1;
        to_cnt_d    = '0;
        state_d     = StWaitHi;
      end
      StWaitHi: begin
        if (busy) begin
          state_d = StWaitLo;
        end else if (to_cnt_q == BusyLast) begin
          err_d = 1'b1;
          if (done_q) begin
            host_done = 1'b1;
            state_d   = StHostIdle;
          end else begin
            advance = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      StWaitLo: begin
        if (!busy) begin
          if (done_q) begin
            host_done = 1'b1;
            if (pend_rd_q) rdata_d = stu_iic_rdata;
            state_d = StHostIdle;
          end else begin
            nack_d  = stu_iic_status[STAT_NACK];
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (nack_q && (retry_q < RetryMax)) begin
          retry_d = retry_q + 8'd1;
          state_d = StIssue;
        end else begin
          if (nack_q) err_d = 1'b1;
          advance = 1'b1;
        end
      end
      StDelay: begin
        if (pluse_us) begin
          if (us_cnt_q == UsLast) begin
            us_cnt_d = '0;
            if (ms_cnt_q + 8'd1 == rom_data[7:0]) advance = 1'b1;
            else ms_cnt_d = ms_cnt_q + 8'd1;
          end else begin
            us_cnt_d = us_cnt_q + 10'd1;
          end
        end
      end
      StHostIdle: begin
        if (pend_q) state_d = StHostIssue;
      end
      StHostIssue: begin
        cfg_devid_d = pend_devid_q;
        cfg_addr_d  = pend_addr_q;
        cfg_wdata_d = pend_wdata_q;
        act_wr_d    = !pend_rd_q;
        act_rd_d    = pend_rd_q;
        to_cnt_d    = '0;
        state_d     = StWaitHi;
      end
      default: state_d = StPwrup;
    endcase

    // Next table entry; index 255 is the last one even without a terminator.
    if (advance) begin
      retry_d = '0;
      if (index_q == 8'hFF) begin
        done_d  = 1'b1;
        state_d = StHostIdle;
      end else begin
        index_d = index_q + 8'd1;
        state_d = StFetch;
      end
    end

    // One-deep host slot; a slot being released this cycle can take a new request.
    if (host_done) pend_d = 1'b0;
    if (host_write || host_read) begin
      if (pend_q && !host_done) begin
        ovf_d = 1'b1;
      end else begin
        pend_d       = 1'b1;
        pend_rd_d    = !host_write;
        pend_devid_d = host_devid;
        pend_addr_d  = host_addr;
        pend_wdata_d = host_wdata;
        if (host_write && host_read) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StPwrup;
      index_q      <= '0;
      fetch_ph_q   <= 1'b0;
      us_cnt_q     <= '0;
      ms_cnt_q     <= '0;
      to_cnt_q     <= '0;
      retry_q      <= '0;
      nack_q       <= 1'b0;
      pend_q       <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_devid_q <= '0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      cfg_devid_q  <= '0;
      cfg_addr_q   <= '0;
      cfg_wdata_q  <= '0;
      act_wr_q     <= 1'b0;
      act_rd_q     <= 1'b0;
      rdata_q      <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      fetch_ph_q   <= fetch_ph_d;
      us_cnt_q     <= us_cnt_d;
      ms_cnt_q     <= ms_cnt_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      nack_q       <= nack_d;
      pend_q       <= pend_d;
      pend_rd_q    <= pend_rd_d;
      pend_devid_q <= pend_devid_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      cfg_devid_q  <= cfg_devid_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_wdata_q  <= cfg_wdata_d;
      act_wr_q     <= act_wr_d;
      act_rd_q     <= act_rd_d;
      rdata_q      <= rdata_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Drops in the very cycle the SCCB master reports completion.
  assign host_busy     = pend_q && !host_done;
  assign host_rdata    = rdata_q;
  assign host_ovf      = ovf_q;
  assign cfg_iic_devid = cfg_devid_q;
  assign cfg_iic_addr  = cfg_addr_q;
  assign cfg_iic_wdata = cfg_wdata_q;
  assign act_iic_write = act_wr_q;
  assign act_iic_read  = act_rd_q;
  assign init_done     = done_q;
  assign init_err      = err_q;

endmodule

// File: tb/tb_ov_init_seq.sv
// Directed bench for ov_init_seq with a small behavioural SCCB master model.
module tb_ov_init_seq;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pluse_us = 1'b0;
  logic [7:0] host_devid, host_addr, host_wdata;
  logic       host_write, host_read;
  logic       host_busy, host_ovf;
  logic [7:0] host_rdata;
  logic [7:0] cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata;
  logic       act_iic_write, act_iic_read;
  logic [1:0] stu_iic_status = 2'b00;
  logic [7:0] stu_iic_rdata = 8'h00;
  logic       init_done, init_err;

  ov_init_seq dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .pluse_us       (pluse_us),
    .host_devid     (host_devid),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_write     (host_write),
    .host_read      (host_read),
    .host_busy      (host_busy),
    .host_rdata     (host_rdata),
    .host_ovf       (host_ovf),
    .cfg_iic_devid  (cfg_iic_devid),
    .cfg_iic_addr   (cfg_iic_addr),
    .cfg_iic_wdata  (cfg_iic_wdata),
    .act_iic_write  (act_iic_write),
    .act_iic_read   (act_iic_read),
    .stu_iic_status (stu_iic_status),
    .stu_iic_rdata  (stu_iic_rdata),
    .init_done      (init_done),
    .init_err       (init_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Model configuration (written by the stimulus block only)
  logic [7:0] nack_addr = 8'h12;
  int         nack_limit = 0;
  logic       no_busy = 1'b0;
  logic [7:0] rd_val = 8'h76;

  // Model state (written by the model block only)
  int         nack_total = 0;
  int         frame = 0;
  logic [7:0] cur_addr = 8'h00;
  logic       ph = 1'b0;
  int         us_now = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] log_dev  [64];
  logic [7:0] log_addr [64];
  logic [7:0] log_data [64];
  int         log_us   [64];

  // 1 us strobe every other cycle, SCCB master with a 6-cycle frame, write logger.
  always @(negedge clk_sys) begin
    ph = !ph;
    pluse_us = ph;
    if (ph) us_now++;
    if (!rst_n) begin
      frame = 0;
      stu_iic_status = 2'b00;
    end else if (frame > 0) begin
      frame--;
      if (frame == 0) begin
        stu_iic_status[0] = 1'b0;
        stu_iic_rdata = rd_val;
        if (cur_addr == nack_addr && nack_total < nack_limit) begin
          stu_iic_status[1] = 1'b1;
          nack_total++;
        end
      end
    end else if ((act_iic_write || act_iic_read) && !no_busy) begin
      frame = 6;
      stu_iic_status = 2'b01;
      cur_addr = cfg_iic_addr;
    end
    if (act_iic_write && wr_cnt < 64) begin
      log_dev[wr_cnt]  = cfg_iic_devid;
      log_addr[wr_cnt] = cfg_iic_addr;
      log_data[wr_cnt] = cfg_iic_wdata;
      log_us[wr_cnt]   = us_now;
      wr_cnt++;
    end
    if (act_iic_read) rd_cnt++;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!init_done && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_host_idle(input int max);
    int n = 0;
    while (host_busy && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
  endtask

  int  base, us_rel, n, c12, wr0, rd0, gap;
  bit  saw_hi;

  initial begin
    rst_n = 1'b0;
    host_devid = 8'h00; host_addr = 8'h00; host_wdata = 8'h00;
    host_write = 1'b0;  host_read = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_init_done", init_done, 0);
    check("rst_init_err", init_err, 0);
    check("rst_host_busy", host_busy, 0);
    check("rst_host_ovf", host_ovf, 0);
    check("rst_act_wr", act_iic_write, 0);
    check("rst_act_rd", act_iic_read, 0);
    check("rst_cfg", {cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata}, 0);
    check("rst_rdata", host_rdata, 0);

    // Run A: acked table, host write during power-up, second write dropped
    base = wr_cnt; us_rel = us_now; rst_n = 1'b1;
    repeat (20) tick();
    host_devid = 8'h60; host_addr = 8'h3A; host_wdata = 8'h04; host_write = 1'b1;
    tick();
    host_write = 1'b0;
    check("a_pend_busy", host_busy, 1);
    check("a_ovf_clear", host_ovf, 0);
    repeat (5) tick();
    host_addr = 8'h55; host_wdata = 8'hAA; host_write = 1'b1;
    tick();
    host_write = 1'b0;
    check("a_ovf_set", host_ovf, 1);
    check("a_still_busy", host_busy, 1);
    wait_done(6000);
    check("a_done", init_done, 1);
    check("a_err", init_err, 0);
    n = 0;
    while (!act_iic_write && n < 20) begin
      tick();
      n++;
    end
    check("a_host_latency", n, 2);
    check("a_host_cfg", {cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata}, 24'h603A04);
    wait_host_idle(100);
    check("a_host_busy_clr", host_busy, 0);
    check("a_wr_count", wr_cnt - base, 3);
    check("a_wr0", {log_dev[base], log_addr[base], log_data[base]}, 24'h421280);
    check("a_wr1", {log_dev[base+1], log_addr[base+1], log_data[base+1]}, 24'h421101);
    check("a_pwrup_ge_1000", (log_us[base] - us_rel) >= 1000, 1);
    gap = log_us[base+1] - log_us[base];
    check("a_gap_ge_1000", gap >= 1000, 1);
    check("a_gap_le_1012", gap <= 1012, 1);

    // Host read after init
    host_devid = 8'h43; host_addr = 8'h0A; host_read = 1'b1;
    tick();
    host_read = 1'b0;
    check("rd_busy_rise", host_busy, 1);
    n = 0;
    while (!act_iic_read && n < 20) begin
      tick();
      n++;
    end
    check("rd_act", act_iic_read, 1);
    check("rd_cfg", {cfg_iic_devid, cfg_iic_addr}, 16'h430A);
    saw_hi = 1'b0;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (stu_iic_status[0]) begin
        if (!saw_hi) check("rd_busy_hold", host_busy, 1);
        saw_hi = 1'b1;
      end else if (saw_hi) begin
        break;
      end
    end
    check("rd_saw_busy", saw_hi, 1);
    check("rd_busy_fall", host_busy, 0);
    @(posedge clk_sys);
    #1;
    check("rd_data", host_rdata, 8'h76);

    // Run B: entry 0 NACKed three times, then acked
    do_reset();
    check("b_rst_ovf", host_ovf, 0);
    check("b_rst_done", init_done, 0);
    nack_limit = nack_total + 3;
    base = wr_cnt; rst_n = 1'b1;
    wait_done(6000);
    c12 = 0;
    for (int i = base; i < wr_cnt && i < 64; i++) if (log_addr[i] == 8'h12) c12++;
    check("b_done", init_done, 1);
    check("b_err", init_err, 0);
    check("b_wr12_count", c12, 4);
    check("b_wr_count", wr_cnt - base, 5);

    // Run C: entry 0 NACKed four times, sequencer continues
    do_reset();
    nack_limit = nack_total + 4;
    base = wr_cnt; rst_n = 1'b1;
    wait_done(6000);
    c12 = 0;
    for (int i = base; i < wr_cnt && i < 64; i++) if (log_addr[i] == 8'h12) c12++;
    check("c_done", init_done, 1);
    check("c_err", init_err, 1);
    check("c_wr12_count", c12, 4);
    check("c_wr_count", wr_cnt - base, 5);
    check("c_last_addr", log_addr[wr_cnt-1], 8'h11);

    // Run D: busy never rises, entries skipped after timeout
    do_reset();
    no_busy = 1'b1;
    base = wr_cnt; rst_n = 1'b1;
    n = 0;
    while (!(act_iic_write && cfg_iic_addr == 8'h11) && n < 6000) begin
      tick();
      n++;
    end
    check("d_act_11", act_iic_write, 1);
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    check("d_timeout_to_done", n, 17);
    check("d_err", init_err, 1);
    check("d_wr_count", wr_cnt - base, 2);
    no_busy = 1'b0;
    check("d_ovf_clear", host_ovf, 0);
    wr0 = wr_cnt; rd0 = rd_cnt;
    host_devid = 8'h42; host_addr = 8'h77; host_wdata = 8'h5A;
    host_write = 1'b1; host_read = 1'b1;
    tick();
    host_write = 1'b0; host_read = 1'b0;
    check("d_both_ovf", host_ovf, 1);
    check("d_both_busy", host_busy, 1);
    wait_host_idle(100);
    check("d_both_idle", host_busy, 0);
    check("d_both_wr", wr_cnt - wr0, 1);
    check("d_both_rd", rd_cnt - rd0, 0);
    check("d_both_addr", log_addr[wr_cnt-1], 8'h77);

    // Run E: reset mid-frame, then the full table is replayed
    do_reset();
    rst_n = 1'b1;
    n = 0;
    while (!act_iic_write && n < 6000) begin
      tick();
      n++;
    end
    check("e_first_act", act_iic_write, 1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("e_rst_act", {act_iic_write, act_iic_read}, 0);
    check("e_rst_cfg", {cfg_iic_devid, cfg_iic_addr, cfg_iic_wdata}, 0);
    check("e_rst_flags", {init_done, init_err, host_busy, host_ovf}, 0);
    repeat (3) tick();
    base = wr_cnt; rst_n = 1'b1;
    wait_done(6000);
    check("e_done", init_done, 1);
    check("e_wr_count", wr_cnt - base, 2);
    check("e_wr0", {log_addr[base], log_data[base]}, 16'h1280);
    check("e_wr1", {log_addr[base+1], log_data[base+1]}, 16'h1101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ov_init_seq.md
# ov_init_seq

Sequencer and arbiter in front of the camera SCCB master (`iic_inf`). After reset it waits a power-up delay and then walks an init table of (register, value) pairs. Each entry becomes one SCCB write, with NACK retry. Once the table finishes, it hands the SCCB master to host commands arriving from the fx-bus register block (`iic_reg`). It sits between `iic_reg` and `iic_inf` inside the camera interface and owns the `cfg_iic_*` and `act_iic_*` signals.

## Interface
- DEVID, 8'h42, SCCB write device id used for table writes
- PWRUP_US, 1000, µs wait after reset before the first table entry
- MAX_RETRY, 3, re-issues per entry after a NACK
- BUSY_TO, 15, clk_sys cycles allowed for busy to rise after a request
- clk_sys  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pluse_us  in  1  one-cycle strobe every 1 µs
- host_devid / host_addr / host_wdata  in  8 each  host command fields from `iic_reg`
- host_write / host_read  in  1  one-cycle host requests
- host_busy  out  1  host command pending or executing
- host_rdata  out  8  last read data
- host_ovf  out  1  sticky: a host request was dropped
- cfg_iic_devid / cfg_iic_addr / cfg_iic_wdata  out  8 each  to `iic_inf`
- act_iic_write / act_iic_read  out  1  one-cycle requests to `iic_inf`
- stu_iic_status  in  2  bit0 busy, bit1 NACK (valid when busy falls)
- stu_iic_rdata  in  8  read data (valid when busy falls)
- init_done  out  1  table complete, level
- init_err  out  1  sticky: an entry failed after retries or a busy timeout occurred

## Operation
- Every output resets to 0.
- States: PWRUP → FETCH → ISSUE → WAIT_HI → WAIT_LO → CHECK → FETCH…, plus DELAY, HOST_IDLE, HOST_ISSUE.
- PWRUP counts PWRUP_US pluse_us strobes, then enters FETCH with index=0.
- FETCH reads `ov_init_rom[index]`, which returns {addr,data}:
  - addr 8'hFF: end of table → set init_done, go to HOST_IDLE.
  - addr 8'hFE: go to DELAY for data×1000 pluse_us strobes. data=0 means no wait. Then index+1 → FETCH.
  - any other addr: ISSUE.
- ISSUE drives cfg_* (devid=DEVID) and pulses act_iic_write for 1 cycle.
- WAIT_HI waits for busy=1. If BUSY_TO cycles pass without busy, set init_err and skip the entry.
- WAIT_LO waits for busy=0.
- CHECK:
  - NACK with retries < MAX_RETRY → ISSUE again.
  - NACK with retries exhausted → set init_err, index+1.
  - No NACK → index+1.
  - Retry count clears on every index advance.
- Index is 8 bits. At index 255 with no terminator, the sequencer treats the table as ended.
- During init, a host request is latched into a one-deep pending slot and host_busy=1. A further request while the slot is occupied is dropped and sets host_ovf. The pending command executes immediately after init_done.
- HOST_IDLE: host_write or host_read (or a pending command) → HOST_ISSUE, using the host fields.
  - Then WAIT_HI/WAIT_LO with the same timeout, no retries.
  - On a read, capture stu_iic_rdata into host_rdata when busy falls.
  - host_busy clears in the same cycle.
- If host_write and host_read are asserted together, the write wins and the read is dropped (host_ovf set).
- Reset at any point aborts the SCCB request and returns the block to PWRUP. Nothing is re-issued mid-frame.

## Timing
- act_* is asserted exactly 1 cycle, 1 cycle after entering ISSUE or HOST_ISSUE.
- cfg_* is stable from that cycle until busy falls.
- Table entry period is roughly the SCCB frame time plus 4 cycles.
- init_done rises 1 cycle after FETCH sees 8'hFF.
- host_busy rises the cycle after a request strobe and falls in the cycle where busy=0 is observed.
- DELAY and PWRUP timing is ±1 µs; the delay counter is 10-bit µs by 8-bit ms.

## Structure
- Shared package `ov_pkg`:
  - state enum
  - END_MARK=8'hFF and DELAY_MARK=8'hFE
  - status bit indices
- Sub-module `ov_init_rom`: synchronous, 1-cycle read, 256×16, with the table contents as constants.
- The FETCH state accounts for the 1-cycle ROM read.

## Test plan
- Table {12→80, FE→01, 11→01, FF}, iic model acks → two writes (12/80, 11/01) ≥1000 µs apart. init_done=1, init_err=0.
- Model NACKs entry 0 three times then acks → 4 act_iic_write pulses for that entry, init_err=0. With 4 NACKs → init_err=1 and the sequencer continues.
- Model never raises busy → after 15 cycles the entry is skipped and init_err=1.
- host_write (addr 3A, data 04) during PWRUP → executes right after init_done. A second host_write during init → host_ovf=1.
- host_read addr 0A after init, model returns 76 → host_rdata=8'h76, host_busy falls when busy falls.
- rst_n asserted mid-frame → all outputs 0, then PWRUP restarts and the full table is replayed.
